// File: rtl/seq_gen_pkg.sv
// Shared definitions for the serial pattern generator.
//   seq_gen_state_t : FSM state encoding (IDLE, SHIFT, GAP, DONE)
//   DEF_*           : default width constants used as module parameter defaults
//   clamp_len       : min(length, max_len)
package seq_gen_pkg;

    localparam int DEF_MAX_LEN = 16;
    localparam int DEF_LEN_W   = 5;
    localparam int DEF_REP_W   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } seq_gen_state_t;

    function automatic int clamp_len(input int len, input int max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register, LSB out first.
//   clk   : clock
//   rst   : asynchronous active-low reset
//   load  : capture din (takes priority over shift)
//   shift : shift right by one, zero fill
//   din   : parallel data
//   sout  : current LSB
module piso_shift_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             sout
);

    logic [WIDTH-1:0] q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= q >> 1;
        end
    end

    assign sout = q[0];

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial bit-pattern generator. Accepts a parallel pattern through a
// valid/ready load, then drives it LSB-first one bit per clock, repeating
// it repeat_n+1 times with GAP_CYCLES idle cycles between repetitions.
//   clk        : clock
//   rst        : asynchronous active-low reset
//   load_valid : load request
//   load_ready : load can be accepted (IDLE only)
//   pattern    : bits to send, bit 0 first
//   length     : bits per repetition (clamped to MAX_LEN)
//   repeat_n   : extra repetitions ("repeat" is a reserved word)
//   out        : serial data, 0 whenever out_valid is low
//   out_valid  : out carries a pattern bit
//   busy       : load accepted, done not yet issued
//   done       : one-cycle pulse after the final bit
module seq_pattern_gen #(
    parameter int MAX_LEN    = seq_gen_pkg::DEF_MAX_LEN,
    parameter int LEN_W      = seq_gen_pkg::DEF_LEN_W,
    parameter int REP_W      = seq_gen_pkg::DEF_REP_W,
    parameter int GAP_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   length,
    input  logic [REP_W-1:0]   repeat_n,
    output logic               out,
    output logic               out_valid,
    output logic               busy,
    output logic               done
);

    import seq_gen_pkg::*;

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    seq_gen_state_t     state;
    logic [LEN_W-1:0]   bit_cnt;
    logic [LEN_W-1:0]   eff_len;
    logic [REP_W-1:0]   rep_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [MAX_LEN-1:0] saved_pat;

    logic               accept;
    logic               reload;
    logic               sh_load;
    logic               sh_shift;
    logic               sh_out;
    logic [MAX_LEN-1:0] sh_din;
    logic [LEN_W-1:0]   len_clamped;

    assign len_clamped = LEN_W'(clamp_len(int'(length), MAX_LEN));
    assign accept      = (state == IDLE) && load_valid && load_ready;

    // A new repetition starts either straight from the last bit (no gap)
    // or at the end of the gap; both restore the saved pattern.
    assign reload = ((state == SHIFT) && (bit_cnt == '0) && (rep_cnt != '0) &&
                     (GAP_CYCLES == 0)) ||
                    ((state == GAP) && (gap_cnt == '0));

    assign sh_load  = accept || reload;
    assign sh_shift = (state == SHIFT);
    assign sh_din   = accept ? pattern : saved_pat;

    piso_shift_reg #(
        .WIDTH (MAX_LEN)
    ) u_shreg (
        .clk   (clk),
        .rst   (rst),
        .load  (sh_load),
        .shift (sh_shift),
        .din   (sh_din),
        .sout  (sh_out)
    );

    // Pattern copy for repetitions; pure data, only meaningful after a load.
    always_ff @(posedge clk) begin
        if (accept) begin
            saved_pat <= pattern;
        end
    end

    // Outputs are registered one edge behind the state, so the first bit
    // appears on the edge after the accepting edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            eff_len    <= '0;
            rep_cnt    <= '0;
            gap_cnt    <= '0;
            out        <= 1'b0;
            out_valid  <= 1'b0;
            load_ready <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            out       <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        load_ready <= 1'b0;
                        busy       <= 1'b1;
                        eff_len    <= len_clamped;
                        rep_cnt    <= repeat_n;
                        bit_cnt    <= len_clamped - 1'b1;
                        state      <= (len_clamped == '0) ? DONE : SHIFT;
                    end else begin
                        load_ready <= 1'b1;
                    end
                end
                SHIFT: begin
                    out       <= sh_out;
                    out_valid <= 1'b1;
                    bit_cnt   <= bit_cnt - 1'b1;
                    if (bit_cnt == '0) begin
                        if (rep_cnt != '0) begin
                            rep_cnt <= rep_cnt - 1'b1;
                            bit_cnt <= eff_len - 1'b1;
                            if (GAP_CYCLES > 0) begin
                                state   <= GAP;
                                gap_cnt <= GAP_W'(GAP_CYCLES - 1);
                            end
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state   <= SHIFT;
                        bit_cnt <= eff_len - 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/seq_pattern_gen.md
# seq_pattern_gen

Serial bit-pattern generator: the transmit end of the single-bit `in`/`out` serial stream that our sequence-detector FSMs consume. It accepts a parallel pattern with a length and repeat count through a valid/ready load handshake. It then drives the pattern LSB-first, one bit per clock, on a registered serial output, inserting a programmable idle gap between repetitions. Its output connects directly to a detector's serial input, both in benches and in on-chip self-test.

## Interface
- `MAX_LEN`, 16: maximum pattern length in bits; also the width of `pattern`.
- `LEN_W`, 5: width of `length`. Must satisfy 2^LEN_W > MAX_LEN.
- `REP_W`, 4: width of `repeat`.
- `GAP_CYCLES`, 1: idle cycles between repetitions. 0 means back-to-back.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `load_valid`  in  1  load request.
- `load_ready`  out  1  block can accept a load (high only in IDLE).
- `pattern`  in  MAX_LEN  bits to send; bit 0 is sent first.
- `length`  in  LEN_W  number of bits per repetition.
- `repeat`  in  REP_W  extra repetitions; total transmissions = repeat+1.
- `out`  out  1  serial data bit.
- `out_valid`  out  1  `out` carries a pattern bit this cycle.
- `busy`  out  1  a load has been accepted and the `done` pulse has not yet been issued.
- `done`  out  1  one-cycle pulse after the last bit of the last repetition.

## Operation
- States: IDLE, SHIFT, GAP, DONE.
- **IDLE**
  - `load_ready`=1.
  - On `load_valid`&&`load_ready`, capture `pattern`, eff_len and `repeat`.
  - eff_len = min(`length`, MAX_LEN).
  - eff_len==0 → DONE (no bits sent). Otherwise → SHIFT, with shift register = pattern and bit_cnt = eff_len-1.
- **SHIFT**
  - `out`=shreg[0], `out_valid`=1.
  - Each cycle the register shifts right and bit_cnt decrements.
  - At bit_cnt==0:
    - rep_cnt>0 and GAP_CYCLES>0 → GAP, rep_cnt decrements.
    - rep_cnt>0 and GAP_CYCLES==0 → reload the saved pattern, stay in SHIFT, rep_cnt decrements.
    - rep_cnt==0 → DONE.
- **GAP**
  - `out`=0, `out_valid`=0, for exactly GAP_CYCLES cycles.
  - Then reload the saved pattern and return to SHIFT.
- **DONE**
  - `done`=1 for one cycle, `busy`=0.
  - → IDLE, with `load_ready`=1 the following cycle.
- **Load rules**
  - `load_valid` outside IDLE is ignored; it is not queued.
  - `pattern`, `length` and `repeat` are sampled only on the accepting edge.
  - Later changes to these inputs have no effect on the transfer in progress.
  - Pattern bits at or above eff_len are never sent.
- **Counter widths**
  - bit_cnt has width LEN_W. rep_cnt has width REP_W.
  - The maximum `repeat` value (2^REP_W-1) gives exactly 2^REP_W transmissions; counters never wrap.

## Timing
- All outputs are registered.
- Reset values: `out`=0, `out_valid`=0, `load_ready`=1, `busy`=0, `done`=0. State is IDLE and all counters are 0.
- **Latency**
  - Load accepted at edge k → first bit valid in the cycle after edge k, i.e. from edge k+1 until edge k+2.
  - Bit i is valid in cycle k+1+i.
- **Single transmission** (repeat=0, length=L)
  - `out_valid` is high for exactly L consecutive cycles.
  - `done` pulses in the cycle immediately after the last bit.
  - `load_ready` returns one cycle after `done`.
- **Repeated transmission** (repeat=R, length=L, gap=G)
  - Total transfer from accept to `done` = (R+1)·L + R·G + 1 cycles.
- **Reset during a transfer**
  - Asserting `rst` mid-transfer forces the reset values immediately (asynchronous).
  - The transfer is discarded with no `done` pulse. Operation resumes in IDLE on the first edge after deassertion.
- When `out_valid`=0, `out` is 0, so a downstream detector sees 0s while the generator is idle.

## Structure
- Package `seq_gen_pkg` holds:
  - the state enum `seq_gen_state_t` (IDLE, SHIFT, GAP, DONE);
  - default width constants MAX_LEN, LEN_W, REP_W;
  - a function for the clamp min(length, MAX_LEN).
- Sub-module `piso_shift_reg` (parallel-in serial-out, parameter WIDTH) holds the register.
  - Ports: clk, rst, load, shift, din[WIDTH], sout.
  - The top-level FSM owns bit_cnt, rep_cnt, gap_cnt and the saved pattern.

## Test plan
- Reset is asserted at 5 ns and released at 7 ns with `load_valid`=0 → all outputs hold reset values; `load_ready`=1.
- Load pattern=16'b1011 (bits 0..3 = 1,1,0,1), length=4, repeat=0 → `out` = 1,1,0,1 over 4 cycles with `out_valid`=1. `done` pulses in cycle 5. `busy` is low only after `done`.
- pattern=16'b01, length=2, repeat=2, GAP_CYCLES=1 → `out_valid` sequence 1,1,0,1,1,0,1,1. Data is 1,0 on each burst. `done` follows at accept+9.
- length=0 → no `out_valid`; `done` pulses 1 cycle after accept. length=31 with MAX_LEN=16 → exactly 16 bits sent.
- `load_valid` held high throughout a transfer with a changing `pattern` → only the first value is sent, with no re-accept until IDLE. A second load on the cycle `load_ready` rises is accepted.
- `rst` pulsed low in the middle of the 3rd bit → `out`/`out_valid`/`busy` go to 0 immediately, no `done` pulse. A following load transfers correctly.
- Output driven into the existing sequence-detector FSM (stimulus 1,0,1,1,0,0,1,1,0) → the detector's `out` matches the sequence produced by the existing hand-driven bench.
